// File: rtl/ram_loader.sv
// Stream loader: writes a picture one pixel per beat, or weights packed nine
// beats to a word, into external pixel/weight memories.
module ram_loader #(
  parameter int picture_size     = 28,
  parameter int SIZE_1           = 8,
  parameter int SIZE_9           = 72,
  parameter int SIZE_address_pix = 13,
  parameter int SIZE_address_wei = 9,
  parameter int NUM_WEI          = 257
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        mode,
  input  logic [SIZE_1-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [SIZE_1-1:0]           dp,
  output logic [SIZE_address_pix-1:0] write_addressp,
  output logic                        we_p,
  output logic [SIZE_9-1:0]           dw,
  output logic [SIZE_address_wei-1:0] write_addressw,
  output logic                        we_w,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  state_o
);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD_P = 2'd1, LOAD_W = 2'd2, DONE = 2'd3} state_t;

  localparam logic [SIZE_address_pix-1:0] PIX_LAST = SIZE_address_pix'(picture_size*picture_size-1);
  localparam logic [SIZE_address_wei-1:0] WEI_LAST = SIZE_address_wei'(NUM_WEI-1);

  state_t                        state_q, state_d;
  logic [SIZE_address_pix-1:0]   pix_cnt_q, pix_cnt_d;
  logic [SIZE_address_wei-1:0]   grp_cnt_q, grp_cnt_d;
  logic [3:0]                    beat_q, beat_d;
  logic [SIZE_9-1:0]             pack_q, pack_d;
  logic [SIZE_1-1:0]             dp_q, dp_d;
  logic [SIZE_address_pix-1:0]   addrp_q, addrp_d;
  logic                          we_p_q, we_p_d;
  logic [SIZE_9-1:0]             dw_q, dw_d;
  logic [SIZE_address_wei-1:0]   addrw_q, addrw_d;
  logic                          we_w_q, we_w_d;
  logic                          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      grp_cnt_q <= '0;
      beat_q    <= '0;
      pack_q    <= '0;
      dp_q      <= '0;
      addrp_q   <= '0;
      we_p_q    <= 1'b0;
      dw_q      <= '0;
      addrw_q   <= '0;
      we_w_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      grp_cnt_q <= grp_cnt_d;
      beat_q    <= beat_d;
      pack_q    <= pack_d;
      dp_q      <= dp_d;
      addrp_q   <= addrp_d;
      we_p_q    <= we_p_d;
      dw_q      <= dw_d;
      addrw_q   <= addrw_d;
      we_w_q    <= we_w_d;
    end
  end

  assign in_ready = (state_q == LOAD_P) || (state_q == LOAD_W);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    grp_cnt_d = grp_cnt_q;
    beat_d    = beat_q;
    pack_d    = pack_q;
    dp_d      = dp_q;
    addrp_d   = addrp_q;
    we_p_d    = 1'b0;
    dw_d      = dw_q;
    addrw_d   = addrw_q;
    we_w_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pix_cnt_d = '0;
          grp_cnt_d = '0;
          beat_d    = '0;
          pack_d    = '0;
          state_d   = mode ? LOAD_W : LOAD_P;
        end
      end
      LOAD_P: begin
        if (accept) begin
          dp_d      = in_data;
          addrp_d   = pix_cnt_q;
          we_p_d    = 1'b1;
          pix_cnt_d = pix_cnt_q + SIZE_address_pix'(1);
          if (pix_cnt_q == PIX_LAST) state_d = DONE;
        end
      end
      LOAD_W: begin
        if (accept) begin
          // Shift left so the first beat of a group ends in the top slot.
          if (beat_q == 4'd8) begin
            dw_d      = {pack_q[SIZE_9-SIZE_1-1:0], in_data};
            addrw_d   = grp_cnt_q;
            we_w_d    = 1'b1;
            beat_d    = '0;
            pack_d    = '0;
            grp_cnt_d = grp_cnt_q + SIZE_address_wei'(1);
            if (grp_cnt_q == WEI_LAST) state_d = DONE;
          end else begin
            pack_d = {pack_q[SIZE_9-SIZE_1-1:0], in_data};
            beat_d = beat_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dp             = dp_q;
  assign write_addressp = addrp_q;
  assign we_p           = we_p_q;
  assign dw             = dw_q;
  assign write_addressw = addrw_q;
  assign we_w           = we_w_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign state_o        = state_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: driver tasks push expected memory writes,
// a negedge monitor pops and compares each strobe.
module tb_ram_loader;

  localparam int PS = 4;
  localparam int NW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  dp;
  logic [12:0] write_addressp;
  logic        we_p;
  logic [71:0] dw;
  logic [8:0]  write_addressw;
  logic        we_w;
  logic        busy;
  logic        done;
  logic [1:0]  state_o;

  ram_loader #(
    .picture_size(PS), .SIZE_1(8), .SIZE_9(72),
    .SIZE_address_pix(13), .SIZE_address_wei(9), .NUM_WEI(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dp(dp), .write_addressp(write_addressp), .we_p(we_p),
    .dw(dw), .write_addressw(write_addressw), .we_w(we_w),
    .busy(busy), .done(done), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;
  int done_exp = 0;

  logic [20:0] pix_q[$];  // {addr[12:0], data[7:0]}
  logic [80:0] wei_q[$];  // {addr[8:0], word[71:0]}
  logic [71:0] wexp[3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of its expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we_p && we_w) chk("we_exclusive", 1, 0);
      if (we_p) begin
        if (pix_q.size() == 0) chk("unexpected_we_p", {115'd0, write_addressp}, 128'hFFFF);
        else chk("pix_write", {107'd0, write_addressp, dp}, {107'd0, pix_q.pop_front()});
      end
      if (we_w) begin
        if (wei_q.size() == 0) chk("unexpected_we_w", {119'd0, write_addressw}, 128'hFFFF);
        else chk("wei_write", {47'd0, write_addressw, dw}, {47'd0, wei_q.pop_front()});
      end
      if (done) begin
        done_seen++;
        chk("done_with_last_strobe",
            {126'd0, (we_p && write_addressp == 13'(PS*PS-1)), (we_w && write_addressw == 9'(NW-1))} != 0,
            1);
      end
    end
  end

  task automatic pulse_start(input logic m);
    start = 1'b1; mode = m;
    @(negedge clk);
    start = 1'b0; mode = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d);
    int t = 0;
    in_data = d; in_valid = 1'b1;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) chk("beat_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin @(negedge clk); t++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk(name, {in_ready, we_p, we_w, busy, done, dp, dw, write_addressp, write_addressw, state_o},
        '0);
  endtask

  // Picture load; gap = idle cycles after each beat, stray = pulse start mid-load and in DONE.
  task automatic picture_load(input logic [7:0] base, input int gap, input bit stray);
    pulse_start(1'b0);
    done_exp++;
    for (int n = 0; n < PS*PS; n++) begin
      pix_q.push_back({13'(n), 8'(base + 8'(n))});
      send_beat(8'(base + 8'(n)));
      for (int g = 0; g < gap; g++) @(negedge clk);
      if (stray && n == 5) pulse_start(1'b1);
    end
    if (gap == 0) begin
      chk("pic_done_pulse", {127'd0, done}, 1);
      if (stray) pulse_start(1'b0);
      else @(negedge clk);
      chk("pic_busy_after_done", {127'd0, busy}, 0);
    end
    wait_idle();
  endtask

  task automatic weight_load(input int beats);
    pulse_start(1'b1);
    if (beats == 9*NW) done_exp++;
    for (int b = 0; b < beats; b++) begin
      if (b % 9 == 8) wei_q.push_back({9'(b / 9), wexp[b / 9]});
      send_beat(8'(b + 1));
    end
  endtask

  initial begin
    wexp[0] = 72'h010203040506070809;
    wexp[1] = 72'h0A0B0C0D0E0F101112;
    wexp[2] = 72'h131415161718191A1B;

    #1 check_zero_outputs("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {126'd0, state_o}, 0);

    picture_load(8'h00, 0, 1'b0);

    weight_load(9*NW);
    chk("wei_done_pulse", {127'd0, done}, 1);
    @(negedge clk);
    chk("wei_busy_after_done", {127'd0, busy}, 0);

    picture_load(8'h80, 2, 1'b0);

    weight_load(13);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("midload_reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_wait_after_reset", {126'd0, state_o}, 0);
    chk("no_pending_after_reset", {96'd0, 32'(wei_q.size())}, 0);

    weight_load(9*NW);
    wait_idle();

    picture_load(8'h40, 0, 1'b1);

    repeat (3) @(negedge clk);
    chk("pix_queue_drained", {96'd0, 32'(pix_q.size())}, 0);
    chk("wei_queue_drained", {96'd0, 32'(wei_q.size())}, 0);
    chk("done_count", {96'd0, 32'(done_seen)}, {96'd0, 32'(done_exp)});
    chk("final_idle", {126'd0, state_o}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameters SHALL be: picture_size, default 28, image side length (pixels per image = picture_size*picture_size); SIZE_1, default 8, width of one value; SIZE_9, default 72, width of one packed 3x3 weight word (=9*SIZE_1); SIZE_address_pix, default 13, pixel write-address width; SIZE_address_wei, default 9, weight write-address width; NUM_WEI, default 257, weight words per load (1..257).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-005 mode  input  1  load type, sampled with start: 0 = picture, 1 = weights.
REQ-006 in_data  input  SIZE_1  stream value.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  loader accepts a beat this cycle; a beat is accepted when in_valid and in_ready are both high at a rising edge.
REQ-009 dp  output  SIZE_1  pixel write data to the pixel memory.
REQ-010 write_addressp  output  SIZE_address_pix  pixel write address.
REQ-011 we_p  output  1  pixel write enable.
REQ-012 dw  output  SIZE_9  weight write data to the weight memory.
REQ-013 write_addressw  output  SIZE_address_wei  weight write address.
REQ-014 we_w  output  1  weight write enable.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_P, LOAD_W, DONE; IDLE->LOAD_P on start&&!mode, IDLE->LOAD_W on start&&mode, LOAD_*->DONE on the edge accepting the final beat, DONE->IDLE unconditionally after one cycle.
REQ-018 in_ready SHALL be high exactly when the state is LOAD_P or LOAD_W; start and mode SHALL be ignored outside IDLE.
REQ-019 LOAD_P: beat number n (0-based) accepted at edge k SHALL register dp=in_data, write_addressp=n, we_p=1 for the cycle following edge k; we_p SHALL be 0 in any cycle not following an accepted beat.
REQ-020 LOAD_P SHALL accept exactly picture_size*picture_size beats, addresses 0..picture_size*picture_size-1 in order, with no gaps or repeats.
REQ-021 LOAD_W: beats SHALL be shifted into a 9-slot pack register, the first beat of each group landing in dw[SIZE_9-1 -: SIZE_1] and the ninth in dw[SIZE_1-1:0].
REQ-022 On the edge accepting the ninth beat of group g, the block SHALL register dw=packed word, write_addressw=g, we_w=1 for the following cycle; beats 1..8 of a group SHALL NOT strobe we_w.
REQ-023 LOAD_W SHALL accept exactly 9*NUM_WEI beats, writing addresses 0..NUM_WEI-1.
REQ-024 in_valid low SHALL stall the load with no writes and no counter change, for any number of cycles.
REQ-025 done SHALL be high exactly during the DONE cycle, coincident with the final we_p/we_w strobe.
REQ-026 start asserted in the DONE cycle SHALL be ignored; a new load starts only from IDLE.
REQ-027 Counters SHALL be cleared on entry to LOAD_P/LOAD_W; a new load SHALL never inherit partial-word or address state.
REQ-028 we_p and we_w SHALL never be high in the same cycle.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, in_ready=0, we_p=0, we_w=0, busy=0, done=0, dp=0, dw=0, write_addressp=0, write_addressw=0, counters and pack register 0.
REQ-030 Reset mid-load SHALL discard any partial weight group with no write issued; after release the block SHALL wait in IDLE for start.

Verification (picture_size=4, SIZE_1=8, SIZE_9=72, NUM_WEI=3)
REQ-031 start, mode=0, stream 0x00..0x0F back-to-back -> we_p on 16 consecutive cycles, address n carries data n, done with address 15, busy low next cycle.
REQ-032 start, mode=1, stream 27 beats 0x01..0x1B -> exactly 3 we_w strobes; address 0 carries 0x010203040506070809, address 2 carries 0x131415161718191A1B; done with the third strobe.
REQ-033 Picture load with in_valid toggling 1,0,0,1,... -> same 16 address/data pairs, no extra strobes, addresses strictly increasing.
REQ-034 Weight load, rst_n pulsed low after beat 13 -> outputs zero asynchronously, only address 0 written, next weight load rewrites from address 0 with fresh packing.
REQ-035 start pulsed during LOAD_P and during DONE -> ignored; no mode change, no restart, exactly one done per accepted start.
